// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: word-organised RAM that enforces burst rules
// (alignment, size, range, 1KB boundary, beat count, SEQ continuity) with a two-cycle ERROR.
module ahb_slave_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_WORDS   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic                  hresp,
   output logic [DATA_WIDTH-1:0] hrdata
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0]   RANGE_L = (ADDR_WIDTH+1)'(MEM_WORDS * NB);
   localparam logic [ADDR_WIDTH-1:0] A_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2:0]            WS_L    = 3'(WAIT_STATES);

   typedef enum logic [2:0] {
      SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
      WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
   } ahb_burst_type;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR1 = 2'd2, S_ERR2 = 2'd3} state_t;

   function automatic logic [4:0] burst_len(input logic [2:0] b);
      case (b)
         SINGLE:         burst_len = 5'd1;
         INCR:           burst_len = 5'd0;
         WRAP4, INCR4:   burst_len = 5'd4;
         WRAP8, INCR8:   burst_len = 5'd8;
         default:        burst_len = 5'd16;
      endcase
   endfunction

   function automatic logic is_wrap(input logic [2:0] b);
      is_wrap = (b == WRAP4) || (b == WRAP8) || (b == WRAP16);
   endfunction

   function automatic logic [NB-1:0] lane_strb(input logic [OFF_W-1:0] off,
                                               input logic [ADDR_WIDTH-1:0] nbytes);
      lane_strb = {NB{1'b0}};
      for (int b = 0; b < NB; b++) begin
         lane_strb[b] = (b >= int'(off)) && (b < int'(off) + int'(nbytes));
      end
   endfunction

   state_t                  state_r, state_nx_s;
   logic [2:0]              wait_cnt_r, wait_nx_s;
   logic                    hreadyout_r, hresp_r;
   logic [DATA_WIDTH-1:0]   hrdata_r;
   logic                    burst_open_r, burst_fixed_r, exp_cross_r;
   logic [2:0]              burst_r;
   logic [4:0]              beats_left_r;
   logic [ADDR_WIDTH-1:0]   exp_addr_r;
   logic                    wr_pend_r;
   logic [IDX_W-1:0]        wr_idx_r;
   logic [NB-1:0]           wr_strb_r;
   logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

   logic                    acc_s, nonseq_s, err_s, done_s, nxt_cross_s;
   logic [2:0]              cur_burst_s;
   logic [4:0]              len_s;
   logic [ADDR_WIDTH-1:0]   bytes_s, bound_s, incr_s, end_s, nxt_exp_s;
   logic [IDX_W-1:0]        rd_idx_s;
   logic [DATA_WIDTH-1:0]   wr_old_s, wr_merge_s, rd_word_s;

   assign hreadyout = hreadyout_r;
   assign hresp     = hresp_r;
   assign hrdata    = hrdata_r;

   // Address-phase decode, burst rule checks and next expected address
   always_comb begin
      acc_s       = hsel && hready && (state_r == S_IDLE) && htrans[1];
      nonseq_s    = (htrans == 2'd2);
      cur_burst_s = nonseq_s ? hburst : burst_r;
      bytes_s     = A_ONE << hsize;
      len_s       = burst_len(cur_burst_s);
      bound_s     = ADDR_WIDTH'(len_s) * bytes_s;
      incr_s      = haddr + bytes_s;
      end_s       = haddr + ADDR_WIDTH'(burst_len(hburst)) * bytes_s;
      nxt_exp_s   = is_wrap(cur_burst_s) ?
                    ((haddr & ~(bound_s - A_ONE)) | (incr_s & (bound_s - A_ONE))) : incr_s;
      nxt_cross_s = !is_wrap(cur_burst_s) && (incr_s[ADDR_WIDTH-1:10] != haddr[ADDR_WIDTH-1:10]);
      err_s = (|(haddr & (bytes_s - A_ONE)))
           || (bytes_s > ADDR_WIDTH'(NB))
           || ({1'b0, haddr} >= RANGE_L)
           || (nonseq_s && (hburst == INCR4 || hburst == INCR8 || hburst == INCR16)
               && (haddr[12:10] != end_s[12:10]))
           || (!nonseq_s && (!burst_open_r || (burst_fixed_r && beats_left_r == 5'd0)
               || (haddr != exp_addr_r) || exp_cross_r));
      rd_idx_s = haddr[OFF_W+IDX_W-1:OFF_W];
   end

   // Write-lane merge and read forwarding from the write committing this cycle
   always_comb begin
      done_s     = hreadyout_r && !hresp_r;
      wr_old_s   = mem[wr_idx_r];
      wr_merge_s = wr_old_s;
      for (int b = 0; b < NB; b++) begin
         if (wr_strb_r[b]) begin
            wr_merge_s[8*b +: 8] = hwdata[8*b +: 8];
         end else begin
            wr_merge_s[8*b +: 8] = wr_old_s[8*b +: 8];
         end
      end
      if (wr_pend_r && done_s && (wr_idx_r == rd_idx_s)) begin
         rd_word_s = wr_merge_s;
      end else begin
         rd_word_s = mem[rd_idx_s];
      end
   end

   // Next-state logic for wait and error sequencing
   always_comb begin
      state_nx_s = state_r;
      wait_nx_s  = wait_cnt_r;
      case (state_r)
         S_IDLE: begin
            if (acc_s && err_s) begin
               state_nx_s = S_ERR1;
            end else if (acc_s && (WS_L != 3'd0)) begin
               state_nx_s = S_WAIT;
               wait_nx_s  = WS_L - 3'd1;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (wait_cnt_r == 3'd0) begin
               state_nx_s = S_IDLE;
            end else begin
               wait_nx_s = wait_cnt_r - 3'd1;
            end
         end
         S_ERR1:  state_nx_s = S_ERR2;
         S_ERR2:  state_nx_s = S_IDLE;
         default: state_nx_s = S_IDLE;
      endcase
   end

   // State, registered responses, read data, burst context and pending write
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_r       <= S_IDLE;
         wait_cnt_r    <= 3'd0;
         hreadyout_r   <= 1'b1;
         hresp_r       <= 1'b0;
         hrdata_r      <= {DATA_WIDTH{1'b0}};
         burst_open_r  <= 1'b0;
         burst_fixed_r <= 1'b0;
         exp_cross_r   <= 1'b0;
         burst_r       <= 3'd0;
         beats_left_r  <= 5'd0;
         exp_addr_r    <= {ADDR_WIDTH{1'b0}};
         wr_pend_r     <= 1'b0;
         wr_idx_r      <= {IDX_W{1'b0}};
         wr_strb_r     <= {NB{1'b0}};
      end else begin
         state_r     <= state_nx_s;
         wait_cnt_r  <= wait_nx_s;
         hreadyout_r <= (state_nx_s == S_IDLE) || (state_nx_s == S_ERR2);
         hresp_r     <= (state_nx_s == S_ERR1) || (state_nx_s == S_ERR2);
         if (acc_s && !err_s && !hwrite) begin
            hrdata_r <= rd_word_s;
         end
         if (acc_s && !err_s && hwrite) begin
            wr_pend_r <= 1'b1;
            wr_idx_r  <= rd_idx_s;
            wr_strb_r <= lane_strb(haddr[OFF_W-1:0], bytes_s);
         end else if (done_s) begin
            wr_pend_r <= 1'b0;
         end
         if (acc_s && err_s) begin
            burst_open_r <= 1'b0;
         end else if (acc_s) begin
            burst_open_r <= 1'b1;
            exp_addr_r   <= nxt_exp_s;
            exp_cross_r  <= nxt_cross_s;
            if (nonseq_s) begin
               burst_r       <= hburst;
               burst_fixed_r <= (hburst != INCR);
               beats_left_r  <= len_s - 5'd1;
            end else begin
               beats_left_r  <= beats_left_r - 5'd1;
            end
         end
      end
   end

   // Memory array, no reset; write lands when its data phase completes OKAY
   always_ff @(posedge hclk) begin
      if (hresetn && wr_pend_r && done_s) begin
         mem[wr_idx_r] <= wr_merge_s;
      end
   end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Cycle-exact vector bench for ahb_slave_mem: one instance with no wait states,
// one with two wait states; each table row is one bus cycle with expected responses.
module tb_ahb_slave_mem;
   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel0, hsel2, hwrite;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic        hready0, hreadyout0, hresp0, hready2, hreadyout2, hresp2;
   logic [31:0] hrdata0, hrdata2;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 hclk = ~hclk;
   assign hready0 = hreadyout0;
   assign hready2 = hreadyout2;

   ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(256), .WAIT_STATES(0)) u0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready0),
      .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0));
   ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(256), .WAIT_STATES(2)) u2 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready2),
      .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2));

   typedef struct {
      logic        u;      // 0: no-wait instance, 1: two-wait instance
      logic        sel;
      logic [1:0]  tr;
      logic        wr;
      logic [2:0]  sz;
      logic [2:0]  bu;
      logic [31:0] ad;
      logic [31:0] wd;
      logic        ex_rdy;
      logic        ex_resp;
      logic        chk;
      logic [31:0] ex_rd;
   } vec_t;
   vec_t tab[$];

   localparam logic [1:0] TI = 2'd0, TB = 2'd1, TN = 2'd2, TS = 2'd3;
   localparam logic [2:0] SGL = 3'd0, INC = 3'd1, W4 = 3'd2, I4 = 3'd3, I16 = 3'd7;

   task automatic add(input logic u, input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] ad,
                      input logic [31:0] wd, input logic ex_rdy, input logic ex_resp,
                      input logic chk, input logic [31:0] ex_rd);
      vec_t v;
      v = '{u, sel, tr, wr, sz, bu, ad, wd, ex_rdy, ex_resp, chk, ex_rd};
      tab.push_back(v);
   endtask

   task automatic drive(input logic u, input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] ad,
                        input logic [31:0] wd);
      hsel0 = sel & ~u;
      hsel2 = sel & u;
      htrans = tr; hwrite = wr; hsize = sz; hburst = bu; haddr = ad; hwdata = wd;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_bus();
      drive(1'b0, 1'b0, TI, 1'b0, 3'd2, SGL, 32'h0, 32'h0);
   endtask

   initial begin
      // no-wait instance: single write/read, WRAP4, error cases
      add(0,1,TN,1,3'd2,SGL,32'h10,32'h0,        1,0,0,32'h0);
      add(0,1,TN,0,3'd2,SGL,32'h10,32'hDEADBEEF, 1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,1,32'hDEADBEEF);
      add(0,1,TN,1,3'd2,W4, 32'h38,32'h0,        1,0,0,32'h0);
      add(0,1,TS,1,3'd2,W4, 32'h3C,32'h1,        1,0,0,32'h0);
      add(0,1,TS,1,3'd2,W4, 32'h30,32'h2,        1,0,0,32'h0);
      add(0,1,TS,1,3'd2,W4, 32'h34,32'h3,        1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h4,        1,0,0,32'h0);
      add(0,1,TN,0,3'd2,W4, 32'h38,32'h0,        1,0,0,32'h0);
      add(0,1,TS,0,3'd2,W4, 32'h3C,32'h0,        1,0,1,32'h1);
      add(0,1,TS,0,3'd2,W4, 32'h30,32'h0,        1,0,1,32'h2);
      add(0,1,TS,0,3'd2,W4, 32'h34,32'h0,        1,0,1,32'h3);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,1,32'h4);
      add(0,1,TN,1,3'd2,W4, 32'h38,32'h0,        1,0,0,32'h0);
      add(0,1,TS,1,3'd2,W4, 32'h40,32'h55,       1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h66,       0,1,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,1,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,0,32'h0);
      // INCR16 crossing 1KB must leave memory untouched
      add(0,1,TN,1,3'd2,SGL,32'h3F0,32'h0,       1,0,0,32'h0);
      add(0,1,TN,1,3'd2,I16,32'h3F0,32'h12345678,1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h77,       0,1,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,1,0,32'h0);
      add(0,1,TN,0,3'd2,SGL,32'h3F0,32'h0,       1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,1,32'h12345678);
      // misaligned halfword, then byte lane write with neighbours preserved
      add(0,1,TN,1,3'd1,SGL,32'h11,32'h0,        1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h9999,     0,1,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,1,0,32'h0);
      add(0,1,TN,1,3'd0,SGL,32'h13,32'h0,        1,0,0,32'h0);
      add(0,1,TN,0,3'd2,SGL,32'h10,32'hAB000000, 1,0,0,32'h0);
      add(0,1,TS,0,3'd2,SGL,32'h14,32'h0,        1,0,1,32'hABADBEEF);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        0,1,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,1,0,32'h0);
      // undefined-length INCR walking onto the 1KB boundary
      add(0,1,TN,0,3'd2,INC,32'h3F8,32'h0,       1,0,0,32'h0);
      add(0,1,TS,0,3'd2,INC,32'h3FC,32'h0,       1,0,0,32'h0);
      add(0,1,TS,0,3'd2,INC,32'h400,32'h0,       1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        0,1,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,1,0,32'h0);
      // unselected transfer ignored; early termination reopens a burst
      add(0,0,TN,1,3'd2,I16,32'h3F0,32'h0,       1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,0,32'h0);
      add(0,1,TN,1,3'd2,I4, 32'h40,32'h0,        1,0,0,32'h0);
      add(0,1,TN,0,3'd2,I4, 32'h60,32'h0000CAFE, 1,0,0,32'h0);
      add(0,1,TS,0,3'd2,I4, 32'h64,32'h0,        1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,0,32'h0);
      add(0,1,TN,0,3'd2,SGL,32'h40,32'h0,        1,0,0,32'h0);
      add(0,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,1,32'h0000CAFE);
      // two-wait instance: INCR4 write, then INCR4 read with BUSY and a 5th SEQ
      add(1,1,TN,1,3'd2,I4, 32'h20,32'h0,        1,0,0,32'h0);
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 3; c++) begin
            add(1,1,TS,1,3'd2,I4, 32'h24 + 32'(4*k), 32'hA0A0A0A1 + 32'(k) * 32'h10101011,
                (c == 2) ? 1'b1 : 1'b0, 0, 0, 32'h0);
         end
      end
      for (int c = 0; c < 3; c++) begin
         add(1,1,TI,0,3'd2,SGL,32'h0,32'hD0D0D0D4, (c == 2) ? 1'b1 : 1'b0, 0, 0, 32'h0);
      end
      add(1,1,TN,0,3'd2,I4, 32'h20,32'h0,        1,0,0,32'h0);
      add(1,1,TS,0,3'd2,I4, 32'h24,32'h0,        0,0,0,32'h0);
      add(1,1,TS,0,3'd2,I4, 32'h24,32'h0,        0,0,0,32'h0);
      add(1,1,TS,0,3'd2,I4, 32'h24,32'h0,        1,0,1,32'hA0A0A0A1);
      add(1,1,TB,0,3'd2,I4, 32'h28,32'h0,        0,0,0,32'h0);
      add(1,1,TB,0,3'd2,I4, 32'h28,32'h0,        0,0,0,32'h0);
      add(1,1,TB,0,3'd2,I4, 32'h28,32'h0,        1,0,1,32'hB0B0B0B2);
      add(1,1,TS,0,3'd2,I4, 32'h28,32'h0,        1,0,1,32'hB0B0B0B2);
      add(1,1,TS,0,3'd2,I4, 32'h2C,32'h0,        0,0,0,32'h0);
      add(1,1,TS,0,3'd2,I4, 32'h2C,32'h0,        0,0,0,32'h0);
      add(1,1,TS,0,3'd2,I4, 32'h2C,32'h0,        1,0,1,32'hC0C0C0C3);
      add(1,1,TS,0,3'd2,I4, 32'h30,32'h0,        0,0,0,32'h0);
      add(1,1,TS,0,3'd2,I4, 32'h30,32'h0,        0,0,0,32'h0);
      add(1,1,TS,0,3'd2,I4, 32'h30,32'h0,        1,0,1,32'hD0D0D0D4);
      add(1,1,TI,0,3'd2,SGL,32'h0, 32'h0,        0,1,0,32'h0);
      add(1,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,1,0,32'h0);
      add(1,1,TI,0,3'd2,SGL,32'h0, 32'h0,        1,0,0,32'h0);

      // reset state of both instances
      hresetn = 1'b0;
      idle_bus();
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;
      @(negedge hclk);
      chk("rst0_rdy", {31'b0, hreadyout0}, 32'd1);
      chk("rst0_resp", {31'b0, hresp0}, 32'd0);
      chk("rst0_rdata", hrdata0, 32'h0);
      chk("rst2_rdy", {31'b0, hreadyout2}, 32'd1);
      chk("rst2_resp", {31'b0, hresp2}, 32'd0);
      chk("rst2_rdata", hrdata2, 32'h0);
      @(posedge hclk); #1;

      for (int i = 0; i < tab.size(); i++) begin
         drive(tab[i].u, tab[i].sel, tab[i].tr, tab[i].wr, tab[i].sz, tab[i].bu,
               tab[i].ad, tab[i].wd);
         @(negedge hclk);
         chk($sformatf("row%0d_rdy", i), {31'b0, tab[i].u ? hreadyout2 : hreadyout0},
             {31'b0, tab[i].ex_rdy});
         chk($sformatf("row%0d_resp", i), {31'b0, tab[i].u ? hresp2 : hresp0},
             {31'b0, tab[i].ex_resp});
         if (tab[i].chk) begin
            chk($sformatf("row%0d_rdata", i), tab[i].u ? hrdata2 : hrdata0, tab[i].ex_rd);
         end
         @(posedge hclk); #1;
      end

      // reset while in ERR1 aborts the error response
      drive(1'b0, 1'b1, TN, 1'b1, 3'd2, SGL, 32'h12, 32'h0);
      @(posedge hclk); #1;
      idle_bus();
      @(negedge hclk);
      chk("err1_rdy", {31'b0, hreadyout0}, 32'd0);
      chk("err1_resp", {31'b0, hresp0}, 32'd1);
      hresetn = 1'b0;
      @(posedge hclk); #1;
      hresetn = 1'b1;
      @(negedge hclk);
      chk("rst_err1_rdy", {31'b0, hreadyout0}, 32'd1);
      chk("rst_err1_resp", {31'b0, hresp0}, 32'd0);
      chk("rst_err1_rdata", hrdata0, 32'h0);
      // SEQ with no open burst after reset
      drive(1'b0, 1'b1, TS, 1'b0, 3'd2, INC, 32'h10, 32'h0);
      @(posedge hclk); #1;
      idle_bus();
      @(negedge hclk);
      chk("seq_norst_rdy", {31'b0, hreadyout0}, 32'd0);
      chk("seq_norst_resp", {31'b0, hresp0}, 32'd1);
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("seq_norst_err2", {30'b0, hreadyout0, hresp0}, 32'd3);
      @(posedge hclk); #1;

      // reset while in WAIT
      drive(1'b1, 1'b1, TN, 1'b0, 3'd2, SGL, 32'h20, 32'h0);
      @(posedge hclk); #1;
      idle_bus();
      @(negedge hclk);
      chk("wait_rdy", {31'b0, hreadyout2}, 32'd0);
      hresetn = 1'b0;
      @(posedge hclk); #1;
      hresetn = 1'b1;
      @(negedge hclk);
      chk("rst_wait_rdy", {31'b0, hreadyout2}, 32'd1);
      chk("rst_wait_resp", {31'b0, hresp2}, 32'd0);
      chk("rst_wait_rdata", hrdata2, 32'h0);
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("rst_wait_idle", {30'b0, hreadyout2, hresp2}, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
